// File: rtl/riscv_core_trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, event kinds,
// cause codes, CSR addresses, mstatus bit positions and privilege encodings.
package riscv_core_trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WR_EPC,
        ST_WR_CAUSE,
        ST_WR_TVAL,
        ST_WR_STATUS,
        ST_REDIRECT
    } trap_state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_EXC,
        EV_IRQ,
        EV_MRET,
        EV_SRET
    } trap_event_e;

    typedef struct packed {
        logic illegal;
        logic ebreak;
        logic ecall;
        logic mret;
        logic sret;
        logic irq;
    } trap_flags_t;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_U = 4'd8;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam int unsigned MSTATUS_SIE    = 1;
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_SPIE   = 5;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_SPP    = 8;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    localparam logic [1:0] TVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/riscv_core_trap_cause_encoder.sv
// Combinational event priority, cause/tval selection and S-mode delegation
// decision for one captured trap request.
module riscv_core_trap_cause_encoder
    import riscv_core_trap_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  trap_flags_t       flags,
    input  logic [5:0]        irq_code,
    input  logic [1:0]        priv,
    input  logic [XLEN-1:0]   medeleg,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       instr,
    output trap_event_e       kind_c,
    output logic [XLEN-1:0]   cause_c,
    output logic [XLEN-1:0]   tval_c,
    output logic              delegate_c
);

    localparam int unsigned IDX_W = $clog2(XLEN);

    logic [3:0] exc_code;

    // Synchronous exceptions win over xret, and everything wins over irq
    always_comb begin
        kind_c   = EV_NONE;
        exc_code = '0;
        tval_c   = '0;
        if (flags.illegal) begin
            kind_c   = EV_EXC;
            exc_code = CAUSE_ILLEGAL;
            tval_c   = XLEN'(instr);
        end else if (flags.ebreak) begin
            kind_c   = EV_EXC;
            exc_code = CAUSE_EBREAK;
            tval_c   = pc;
        end else if (flags.ecall) begin
            kind_c   = EV_EXC;
            exc_code = CAUSE_ECALL_U + 4'(priv);
        end else if (flags.mret) begin
            kind_c = EV_MRET;
        end else if (flags.sret) begin
            kind_c = EV_SRET;
        end else if (flags.irq) begin
            kind_c = EV_IRQ;
        end
    end

    always_comb begin
        cause_c = '0;
        if (kind_c == EV_EXC) begin
            cause_c = XLEN'(exc_code);
        end else if (kind_c == EV_IRQ) begin
            cause_c = {1'b1, {(XLEN-7){1'b0}}, irq_code};
        end
    end

    assign delegate_c = (kind_c == EV_EXC) && (priv != PRIV_M)
                        && medeleg[IDX_W'(exc_code)];

endmodule

// File: rtl/riscv_core_trap_sequencer.sv
// Trap/xret sequencer: accepts one event, flushes, writes epc/cause/tval/status
// CSRs in turn and redirects the PC. Outputs are registered from the current state.
module riscv_core_trap_sequencer
    import riscv_core_trap_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic              i_trap_seq_clk,
    input  logic              i_trap_seq_rst,
    input  logic              i_trap_seq_valid,
    input  logic              i_trap_seq_ecall,
    input  logic              i_trap_seq_ebreak,
    input  logic              i_trap_seq_mret,
    input  logic              i_trap_seq_sret,
    input  logic              i_trap_seq_illegal,
    input  logic              i_trap_seq_irq,
    input  logic [5:0]        i_trap_seq_irq_code,
    input  logic [XLEN-1:0]   i_trap_seq_pc,
    input  logic [31:0]       i_trap_seq_instr,
    input  logic [XLEN-1:0]   i_trap_seq_mstatus,
    input  logic [XLEN-1:0]   i_trap_seq_mtvec,
    input  logic [XLEN-1:0]   i_trap_seq_stvec,
    input  logic [XLEN-1:0]   i_trap_seq_mepc,
    input  logic [XLEN-1:0]   i_trap_seq_sepc,
    input  logic [XLEN-1:0]   i_trap_seq_medeleg,
    output logic              o_trap_seq_ack,
    output logic              o_trap_seq_busy,
    output logic              o_trap_seq_flush,
    output logic              o_trap_seq_csr_wen,
    output logic [11:0]       o_trap_seq_csr_addr,
    output logic [XLEN-1:0]   o_trap_seq_csr_wdata,
    output logic              o_trap_seq_redirect,
    output logic [XLEN-1:0]   o_trap_seq_redirect_pc,
    output logic [1:0]        o_trap_seq_priv
);

    trap_state_e     state, state_nxt;
    trap_flags_t     cap_flags;
    logic [5:0]      cap_irq_code;
    logic [31:0]     cap_instr;
    logic [1:0]      cap_priv;
    logic [XLEN-1:0] cap_pc, cap_mstatus, cap_mtvec, cap_stvec;
    logic [XLEN-1:0] cap_mepc, cap_sepc, cap_medeleg;

    trap_event_e     kind_c;
    logic [XLEN-1:0] cause_c, tval_c, status_new_c, target_c, tvec_c;
    logic            delegate_c, accept_c;
    logic [1:0]      priv_new_c;

    logic            ack_nxt, busy_nxt, flush_nxt, wen_nxt, redirect_nxt;
    logic [11:0]     addr_nxt;
    logic [XLEN-1:0] wdata_nxt, redirect_pc_nxt;
    logic [1:0]      priv_nxt;

    assign accept_c = (state == ST_IDLE) && i_trap_seq_valid;

    // Request snapshot; the whole sequence works from these copies
    always_ff @(posedge i_trap_seq_clk or posedge i_trap_seq_rst) begin
        if (i_trap_seq_rst) begin
            cap_flags    <= '0;
            cap_irq_code <= '0;
            cap_instr    <= '0;
            cap_priv     <= PRIV_M;
            cap_pc       <= '0;
            cap_mstatus  <= '0;
            cap_mtvec    <= '0;
            cap_stvec    <= '0;
            cap_mepc     <= '0;
            cap_sepc     <= '0;
            cap_medeleg  <= '0;
        end else if (accept_c) begin
            cap_flags    <= '{illegal: i_trap_seq_illegal, ebreak: i_trap_seq_ebreak,
                              ecall: i_trap_seq_ecall, mret: i_trap_seq_mret,
                              sret: i_trap_seq_sret, irq: i_trap_seq_irq};
            cap_irq_code <= i_trap_seq_irq_code;
            cap_instr    <= i_trap_seq_instr;
            cap_priv     <= o_trap_seq_priv;
            cap_pc       <= i_trap_seq_pc;
            cap_mstatus  <= i_trap_seq_mstatus;
            cap_mtvec    <= i_trap_seq_mtvec;
            cap_stvec    <= i_trap_seq_stvec;
            cap_mepc     <= i_trap_seq_mepc;
            cap_sepc     <= i_trap_seq_sepc;
            cap_medeleg  <= i_trap_seq_medeleg;
        end
    end

    riscv_core_trap_cause_encoder #(.XLEN(XLEN)) u_cause_encoder (
        .flags      (cap_flags),
        .irq_code   (cap_irq_code),
        .priv       (cap_priv),
        .medeleg    (cap_medeleg),
        .pc         (cap_pc),
        .instr      (cap_instr),
        .kind_c     (kind_c),
        .cause_c    (cause_c),
        .tval_c     (tval_c),
        .delegate_c (delegate_c)
    );

    // New mstatus image and privilege for the event being retired
    always_comb begin
        status_new_c = cap_mstatus;
        priv_new_c   = o_trap_seq_priv;
        case (kind_c)
            EV_EXC, EV_IRQ: begin
                if (delegate_c) begin
                    status_new_c[MSTATUS_SPIE] = cap_mstatus[MSTATUS_SIE];
                    status_new_c[MSTATUS_SIE]  = 1'b0;
                    status_new_c[MSTATUS_SPP]  = cap_priv[0];
                    priv_new_c                 = PRIV_S;
                end else begin
                    status_new_c[MSTATUS_MPIE]          = cap_mstatus[MSTATUS_MIE];
                    status_new_c[MSTATUS_MIE]           = 1'b0;
                    status_new_c[MSTATUS_MPP_LO +: 2]   = cap_priv;
                    priv_new_c                          = PRIV_M;
                end
            end
            EV_MRET: begin
                status_new_c[MSTATUS_MIE]         = cap_mstatus[MSTATUS_MPIE];
                status_new_c[MSTATUS_MPIE]        = 1'b1;
                status_new_c[MSTATUS_MPP_LO +: 2] = PRIV_U;
                priv_new_c                        = cap_mstatus[MSTATUS_MPP_LO +: 2];
            end
            EV_SRET: begin
                status_new_c[MSTATUS_SIE]  = cap_mstatus[MSTATUS_SPIE];
                status_new_c[MSTATUS_SPIE] = 1'b1;
                status_new_c[MSTATUS_SPP]  = 1'b0;
                priv_new_c                 = {1'b0, cap_mstatus[MSTATUS_SPP]};
            end
            default: ;
        endcase
    end

    // Redirect target: tvec base, vectored only for interrupts, or the saved epc
    assign tvec_c = delegate_c ? cap_stvec : cap_mtvec;
    always_comb begin
        target_c = {tvec_c[XLEN-1:2], 2'b00};
        if (kind_c == EV_IRQ && tvec_c[1:0] == TVEC_MODE_VECTORED) begin
            target_c = {tvec_c[XLEN-1:2], 2'b00} + (XLEN'(cap_irq_code) << 2);
        end else if (kind_c == EV_MRET) begin
            target_c = cap_mepc;
        end else if (kind_c == EV_SRET) begin
            target_c = cap_sepc;
        end
    end

    always_comb begin
        state_nxt       = state;
        ack_nxt         = accept_c;
        busy_nxt        = (state != ST_IDLE) || accept_c;
        flush_nxt       = 1'b0;
        wen_nxt         = 1'b0;
        addr_nxt        = '0;
        wdata_nxt       = '0;
        redirect_nxt    = 1'b0;
        redirect_pc_nxt = '0;
        priv_nxt        = o_trap_seq_priv;
        case (state)
            ST_IDLE: begin
                if (i_trap_seq_valid) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_nxt = 1'b1;
                case (kind_c)
                    EV_EXC, EV_IRQ:   state_nxt = ST_WR_EPC;
                    EV_MRET, EV_SRET: state_nxt = ST_WR_STATUS;
                    default:          state_nxt = ST_IDLE;
                endcase
            end
            ST_WR_EPC: begin
                wen_nxt   = 1'b1;
                addr_nxt  = delegate_c ? CSR_SEPC : CSR_MEPC;
                wdata_nxt = cap_pc;
                state_nxt = ST_WR_CAUSE;
            end
            ST_WR_CAUSE: begin
                wen_nxt   = 1'b1;
                addr_nxt  = delegate_c ? CSR_SCAUSE : CSR_MCAUSE;
                wdata_nxt = cause_c;
                state_nxt = ST_WR_TVAL;
            end
            ST_WR_TVAL: begin
                wen_nxt   = 1'b1;
                addr_nxt  = delegate_c ? CSR_STVAL : CSR_MTVAL;
                wdata_nxt = tval_c;
                state_nxt = ST_WR_STATUS;
            end
            ST_WR_STATUS: begin
                wen_nxt   = 1'b1;
                addr_nxt  = CSR_MSTATUS;
                wdata_nxt = status_new_c;
                priv_nxt  = priv_new_c;
                state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_nxt    = 1'b1;
                redirect_pc_nxt = target_c;
                state_nxt       = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_trap_seq_clk or posedge i_trap_seq_rst) begin
        if (i_trap_seq_rst) begin
            state                  <= ST_IDLE;
            o_trap_seq_ack         <= 1'b0;
            o_trap_seq_busy        <= 1'b0;
            o_trap_seq_flush       <= 1'b0;
            o_trap_seq_csr_wen     <= 1'b0;
            o_trap_seq_csr_addr    <= '0;
            o_trap_seq_csr_wdata   <= '0;
            o_trap_seq_redirect    <= 1'b0;
            o_trap_seq_redirect_pc <= '0;
            o_trap_seq_priv        <= PRIV_M;
        end else begin
            state                  <= state_nxt;
            o_trap_seq_ack         <= ack_nxt;
            o_trap_seq_busy        <= busy_nxt;
            o_trap_seq_flush       <= flush_nxt;
            o_trap_seq_csr_wen     <= wen_nxt;
            o_trap_seq_csr_addr    <= addr_nxt;
            o_trap_seq_csr_wdata   <= wdata_nxt;
            o_trap_seq_redirect    <= redirect_nxt;
            o_trap_seq_redirect_pc <= redirect_pc_nxt;
            o_trap_seq_priv        <= priv_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_core_trap_sequencer.sv
// Scoreboard bench for the trap sequencer: expected CSR writes and redirects are
// queued per request and matched by a monitor as the DUT produces them.
module tb_riscv_core_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ecall, ebreak, mret, sret, illegal, irq;
    logic [5:0]  irq_code;
    logic [63:0] pc, mstatus, mtvec, stvec, mepc, sepc, medeleg;
    logic [31:0] instr;
    logic        ack, busy, flush, csr_wen, redirect;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, redirect_pc;
    logic [1:0]  priv;

    typedef struct packed {
        logic        is_redir;
        logic [11:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_wr    = 0;
    int   n_redir = 0;
    int   n_flush = 0;

    always #5 clk = ~clk;

    riscv_core_trap_sequencer #(.XLEN(64)) dut (
        .i_trap_seq_clk         (clk),
        .i_trap_seq_rst         (rst),
        .i_trap_seq_valid       (valid),
        .i_trap_seq_ecall       (ecall),
        .i_trap_seq_ebreak      (ebreak),
        .i_trap_seq_mret        (mret),
        .i_trap_seq_sret        (sret),
        .i_trap_seq_illegal     (illegal),
        .i_trap_seq_irq         (irq),
        .i_trap_seq_irq_code    (irq_code),
        .i_trap_seq_pc          (pc),
        .i_trap_seq_instr       (instr),
        .i_trap_seq_mstatus     (mstatus),
        .i_trap_seq_mtvec       (mtvec),
        .i_trap_seq_stvec       (stvec),
        .i_trap_seq_mepc        (mepc),
        .i_trap_seq_sepc        (sepc),
        .i_trap_seq_medeleg     (medeleg),
        .o_trap_seq_ack         (ack),
        .o_trap_seq_busy        (busy),
        .o_trap_seq_flush       (flush),
        .o_trap_seq_csr_wen     (csr_wen),
        .o_trap_seq_csr_addr    (csr_addr),
        .o_trap_seq_csr_wdata   (csr_wdata),
        .o_trap_seq_redirect    (redirect),
        .o_trap_seq_redirect_pc (redirect_pc),
        .o_trap_seq_priv        (priv)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [11:0] addr, input logic [63:0] data);
        sb.push_back('{is_redir: 1'b0, addr: addr, data: data});
    endtask

    task automatic push_redir(input logic [63:0] target);
        sb.push_back('{is_redir: 1'b1, addr: 12'h000, data: target});
    endtask

    task automatic clear_inputs();
        valid = 0; ecall = 0; ebreak = 0; mret = 0; sret = 0; illegal = 0; irq = 0;
        irq_code = '0; pc = '0; instr = '0; mstatus = '0; mtvec = '0; stvec = '0;
        mepc = '0; sepc = '0; medeleg = '0;
    endtask

    task automatic scramble();
        ecall = 1'($urandom); ebreak = 1'($urandom); mret = 1'($urandom);
        sret = 1'($urandom); illegal = 1'($urandom); irq = 1'($urandom);
        irq_code = 6'($urandom); instr = $urandom;
        pc = {$urandom, $urandom}; mstatus = {$urandom, $urandom};
        mtvec = {$urandom, $urandom}; stvec = {$urandom, $urandom};
        mepc = {$urandom, $urandom}; sepc = {$urandom, $urandom};
        medeleg = {$urandom, $urandom};
    endtask

    // Monitor: every CSR write and redirect must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (flush) n_flush++;
        if (csr_wen) begin
            n_wr++;
            if (sb.size() == 0) begin
                check_eq("sb_underflow_wr", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check_eq("wr_kind", 64'(e.is_redir), 64'd0);
                check_eq("wr_addr", 64'(csr_addr), 64'(e.addr));
                check_eq("wr_data", csr_wdata, e.data);
            end
        end
        if (redirect) begin
            n_redir++;
            if (sb.size() == 0) begin
                check_eq("sb_underflow_redir", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check_eq("redir_kind", 64'(e.is_redir), 64'd1);
                check_eq("redir_pc", redirect_pc, e.data);
            end
        end
    end

    // Issue the staged request, then scramble inputs and measure ack-to-redirect
    task automatic run_seq(input string tag, input int exp_lat, input logic [1:0] exp_priv);
        int wr0, fl0, lat;
        bit got;
        fl0 = n_flush;
        wr0 = n_wr;
        got = 0;
        valid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                break;
            end
        end
        check_eq({tag, "_ack"}, 64'(got), 64'd1);
        check_eq({tag, "_busy_at_ack"}, 64'(busy), 64'd1);
        valid = 0;
        scramble();
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (redirect && lat == 0) lat = i;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_priv"}, 64'(priv), 64'(exp_priv));
        check_eq({tag, "_busy_idle"}, 64'(busy), 64'd0);
        check_eq({tag, "_flushes"}, 64'(n_flush - fl0), 64'd1);
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        if (exp_lat == 0) check_eq({tag, "_no_writes"}, 64'(n_wr - wr0), 64'd0);
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0, rd0, k2, busy_low;
        bit got;
        clear_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        check_eq("rst_ack", 64'(ack), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_flush", 64'(flush), 64'd0);
        check_eq("rst_wen", 64'(csr_wen), 64'd0);
        check_eq("rst_addr", 64'(csr_addr), 64'd0);
        check_eq("rst_wdata", csr_wdata, 64'd0);
        check_eq("rst_redirect", 64'(redirect), 64'd0);
        check_eq("rst_redirect_pc", redirect_pc, 64'd0);
        check_eq("rst_priv", 64'(priv), 64'd3);
        rst = 0;
        @(negedge clk);

        // mret from M with MPP=U drops to U
        mret = 1; mepc = 64'h100;
        push_wr(12'h300, 64'h80); push_redir(64'h100);
        run_seq("mret_to_u", 3, 2'b00);

        // ecall from U into M
        ecall = 1; pc = 64'h8000_0010; mtvec = 64'h8000_0100; mstatus = 64'h8;
        push_wr(12'h341, 64'h8000_0010); push_wr(12'h342, 64'd8); push_wr(12'h343, 64'd0);
        push_wr(12'h300, 64'h80); push_redir(64'h8000_0100);
        run_seq("ecall_u", 6, 2'b11);

        mret = 1; mepc = 64'h100;
        push_wr(12'h300, 64'h80); push_redir(64'h100);
        run_seq("mret_to_u2", 3, 2'b00);

        // illegal from U, delegated to S
        illegal = 1; instr = 32'hFFFF_FFFF; pc = 64'h1234; medeleg = 64'h4;
        stvec = 64'h2000; mtvec = 64'h9000; mstatus = 64'h2;
        push_wr(12'h141, 64'h1234); push_wr(12'h142, 64'd2); push_wr(12'h143, 64'hFFFF_FFFF);
        push_wr(12'h300, 64'h20); push_redir(64'h2000);
        run_seq("illegal_deleg", 6, 2'b01);

        // vectored interrupt from S, never delegated
        irq = 1; irq_code = 6'd7; mtvec = 64'h1001; stvec = 64'h7000;
        medeleg = '1; pc = 64'h5000;
        push_wr(12'h341, 64'h5000); push_wr(12'h342, 64'h8000_0000_0000_0007);
        push_wr(12'h343, 64'd0); push_wr(12'h300, 64'h800); push_redir(64'h101C);
        run_seq("irq_vec", 6, 2'b11);

        // mret with MPP=S, MPIE=1
        mret = 1; mstatus = 64'h880; mepc = 64'h4000;
        push_wr(12'h300, 64'h88); push_redir(64'h4000);
        run_seq("mret_to_s", 3, 2'b01);

        // ecall and irq together from S: exception wins, no vectoring
        ecall = 1; irq = 1; irq_code = 6'd5; pc = 64'h6000; mtvec = 64'h3001;
        push_wr(12'h341, 64'h6000); push_wr(12'h342, 64'd9); push_wr(12'h343, 64'd0);
        push_wr(12'h300, 64'h800); push_redir(64'h3000);
        run_seq("ecall_irq_s", 6, 2'b11);

        // ebreak from M: tval is pc, medeleg ignored in M
        ebreak = 1; pc = 64'h7000; mtvec = 64'h3000; medeleg = 64'hFFFF; mstatus = 64'h8;
        push_wr(12'h341, 64'h7000); push_wr(12'h342, 64'd3); push_wr(12'h343, 64'h7000);
        push_wr(12'h300, 64'h1880); push_redir(64'h3000);
        run_seq("ebreak_m", 6, 2'b11);

        // empty request: ack and flush only
        pc = 64'hDEAD; mtvec = 64'hBEE0;
        run_seq("none", 0, 2'b11);

        // sret with SPP=1, SPIE=1
        sret = 1; mstatus = 64'h120; sepc = 64'h9000;
        push_wr(12'h300, 64'h22); push_redir(64'h9000);
        run_seq("sret_to_s", 3, 2'b01);

        // reset while the sequencer is in WR_CAUSE
        ecall = 1; pc = 64'hC000; mtvec = 64'hD000;
        push_wr(12'h341, 64'hC000);
        wr0 = n_wr; rd0 = n_redir; got = 0;
        valid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                break;
            end
        end
        check_eq("rstmid_ack", 64'(got), 64'd1);
        valid = 0;
        repeat (2) @(negedge clk);
        #1 rst = 1;
        @(negedge clk);
        check_eq("rstmid_wen", 64'(csr_wen), 64'd0);
        check_eq("rstmid_redirect", 64'(redirect), 64'd0);
        check_eq("rstmid_priv", 64'(priv), 64'd3);
        check_eq("rstmid_busy", 64'(busy), 64'd0);
        rst = 0;
        repeat (10) @(negedge clk);
        check_eq("rstmid_writes", 64'(n_wr - wr0), 64'd1);
        check_eq("rstmid_redirects", 64'(n_redir - rd0), 64'd0);
        check_eq("rstmid_sb_empty", 64'(sb.size()), 64'd0);
        clear_inputs();

        // valid held through a whole sequence: second ack only once back in IDLE
        ecall = 1; pc = 64'hA000; mtvec = 64'hB000;
        for (int r = 0; r < 2; r++) begin
            push_wr(12'h341, 64'hA000); push_wr(12'h342, 64'd11); push_wr(12'h343, 64'd0);
            push_wr(12'h300, 64'h1800); push_redir(64'hB000);
        end
        rd0 = n_redir; got = 0; k2 = 0; busy_low = 0;
        valid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                break;
            end
        end
        check_eq("hold_ack1", 64'(got), 64'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!busy && k <= 6) busy_low++;
            if (ack && k2 == 0) begin
                k2 = k;
                valid = 0;
            end
        end
        valid = 0;
        check_eq("hold_ack2_cycle", 64'(k2), 64'd7);
        check_eq("hold_busy_gap", 64'(busy_low), 64'd0);
        repeat (10) @(negedge clk);
        check_eq("hold_redirects", 64'(n_redir - rd0), 64'd2);
        check_eq("hold_sb_empty", 64'(sb.size()), 64'd0);
        check_eq("hold_priv", 64'(priv), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
